// File: rtl/disp_pkg.sv
// Shared constants, types and segment decode for the hex 7-segment scanner.
package disp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AN_W   = 8;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF  = 8'hFF;

  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [SEG_W-1:0] hex7(input logic [NIB_W-1:0] nibble);
    logic [SEG_W-1:0] pat;
    case (nibble)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running divider; tick is high for one cycle every DIV clocks.
module disp_prescaler #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  if (DIV < 2) begin : g_bad_div
    $error("disp_prescaler: DIV must be >= 2");
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(DIV - 1)) cnt_d = '0;
  end

  // tick_q is precomputed from the next count so it is high exactly while cnt_q == DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CW'(DIV - 1));
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/disp_hex_scan.sv
// 8-digit multiplexed hex display driver with per-frame snapshot and leading-zero blanking.
module disp_hex_scan
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_reg,
  input  logic              en,
  input  logic              blank_lz,
  output logic [AN_W-1:0]   an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic              frame_done
);

  if (NUM_DIGITS != 8) begin : g_bad_digits
    $error("disp_hex_scan: NUM_DIGITS must be 8");
  end

  logic              tick;
  digit_idx_t        digit_q, digit_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              frame_done_q, frame_done_d;
  logic [AN_W-1:0]   an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [4:0]        nib_base;
  logic [NIB_W-1:0]  nibble;
  logic [DATA_W-1:0] upper;
  logic              blank;
  logic              snap;

  disp_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Scan position and frame snapshot.
  always_comb begin
    snap         = tick && (digit_q == digit_idx_t'(7));
    digit_d      = digit_q;
    shadow_d     = shadow_q;
    frame_done_d = snap;
    if (tick) digit_d = digit_q + digit_idx_t'(1);
    if (snap) shadow_d = data_reg;
  end

  // Digit i is blank when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    nib_base = {digit_q, 2'b00};
    nibble   = shadow_q[nib_base +: NIB_W];
    upper    = shadow_q >> nib_base;
    blank    = blank_lz && (digit_q != '0) && (upper == '0);
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    if (en && !blank) begin
      an_d  = ~(AN_W'(1) << digit_q);
      seg_d = hex7(nibble);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q      <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_hex_scan.sv
// Directed bench for disp_hex_scan with REFRESH_DIV=4 (slot=4 cycles, frame=32 cycles).
module tb_disp_hex_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_reg = 32'h0;
  logic        en = 1'b1;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  vec_t       v1 [16];
  logic [6:0] sw_lo [8];
  logic [6:0] sw_hi [8];

  disp_hex_scan #(
    .REFRESH_DIV (4),
    .NUM_DIGITS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_reg   (data_reg),
    .en         (en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] an_e, input logic [6:0] seg_e,
                     input logic fd_e);
    checks++;
    if (an !== an_e) begin
      errors++;
      $display("FAIL %s cyc=%0d an got %h want %h", name, cyc, an, an_e);
    end
    checks++;
    if (seg !== seg_e) begin
      errors++;
      $display("FAIL %s cyc=%0d seg got %h want %h", name, cyc, seg, seg_e);
    end
    checks++;
    if (frame_done !== fd_e) begin
      errors++;
      $display("FAIL %s cyc=%0d frame_done got %b want %b", name, cyc, frame_done, fd_e);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL %s cyc=%0d dp got %b want 1", name, cyc, dp);
    end
  endtask

  // After return, outputs reflect the state after posedge number c.
  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic [31:0] d, input logic e, input logic b);
    @(negedge clk);
    rst      = 1'b0;
    data_reg = d;
    en       = e;
    blank_lz = b;
    repeat (2) @(negedge clk);
    chk("reset", 8'hFF, 7'h7F, 1'b0);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    v1[0]  = '{1,  8'hFE, 7'h40, 1'b0};
    v1[1]  = '{4,  8'hFE, 7'h40, 1'b0};
    v1[2]  = '{5,  8'hFD, 7'h40, 1'b0};
    v1[3]  = '{17, 8'hEF, 7'h40, 1'b0};
    v1[4]  = '{31, 8'h7F, 7'h40, 1'b0};
    v1[5]  = '{32, 8'h7F, 7'h40, 1'b1};
    v1[6]  = '{33, 8'hFE, 7'h00, 1'b0};
    v1[7]  = '{36, 8'hFE, 7'h00, 1'b0};
    v1[8]  = '{37, 8'hFD, 7'h78, 1'b0};
    v1[9]  = '{41, 8'hFB, 7'h02, 1'b0};
    v1[10] = '{45, 8'hF7, 7'h12, 1'b0};
    v1[11] = '{49, 8'hEF, 7'h19, 1'b0};
    v1[12] = '{53, 8'hDF, 7'h30, 1'b0};
    v1[13] = '{57, 8'hBF, 7'h24, 1'b0};
    v1[14] = '{61, 8'h7F, 7'h79, 1'b0};
    v1[15] = '{64, 8'h7F, 7'h79, 1'b1};
    sw_lo = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    sw_hi = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    // Basic scan: first frame shows zeros, second frame shows 12345678.
    do_reset(32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_to(v1[i].c);
      chk("scan", v1[i].an, v1[i].seg, v1[i].fd);
    end

    // Snapshot isolation: data change at digit 3 is not visible until the next frame.
    run_to(77);
    data_reg = 32'hFFFFFFFF;
    run_to(81);  chk("iso_d4", 8'hEF, 7'h19, 1'b0);
    run_to(93);  chk("iso_d7", 8'h7F, 7'h79, 1'b0);
    run_to(96);  chk("iso_fd", 8'h7F, 7'h79, 1'b1);
    run_to(97);  chk("iso_new0", 8'hFE, 7'h0E, 1'b0);
    run_to(125); chk("iso_new7", 8'h7F, 7'h0E, 1'b0);

    // Leading-zero blanking.
    do_reset(32'h000000A0, 1'b1, 1'b1);
    run_to(1);  chk("blz0_d0", 8'hFE, 7'h40, 1'b0);
    run_to(5);  chk("blz0_d1", 8'hFF, 7'h7F, 1'b0);
    run_to(33); chk("blz_d0", 8'hFE, 7'h40, 1'b0);
    run_to(37); chk("blz_d1", 8'hFD, 7'h08, 1'b0);
    data_reg = 32'h0;
    run_to(41); chk("blz_d2", 8'hFF, 7'h7F, 1'b0);
    run_to(61); chk("blz_d7", 8'hFF, 7'h7F, 1'b0);
    run_to(65); chk("blzz_d0", 8'hFE, 7'h40, 1'b0);
    run_to(69); chk("blzz_d1", 8'hFF, 7'h7F, 1'b0);
    run_to(70);
    blank_lz = 1'b0;
    run_to(71); chk("blz_off", 8'hFD, 7'h40, 1'b0);

    // Display enable: outputs off next cycle, scan keeps running.
    run_to(72);
    en = 1'b0;
    run_to(73); chk("en_off", 8'hFF, 7'h7F, 1'b0);
    run_to(95); chk("en_off95", 8'hFF, 7'h7F, 1'b0);
    run_to(96); chk("en_off_fd", 8'hFF, 7'h7F, 1'b1);
    run_to(98);
    en = 1'b1;
    run_to(99);  chk("en_on_d0", 8'hFE, 7'h40, 1'b0);
    run_to(103); chk("en_on_d1", 8'hFD, 7'h40, 1'b0);

    // Async reset between edges at digit 5 and while frame_done is high.
    do_reset(32'h12345678, 1'b1, 1'b0);
    run_to(54); chk("pre_rst", 8'hDF, 7'h30, 1'b0);
    #2 rst = 1'b0;
    #1 chk("async_rst", 8'hFF, 7'h7F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run_to(1);  chk("post_rst_d0", 8'hFE, 7'h40, 1'b0);
    run_to(32); chk("post_rst_fd", 8'h7F, 7'h40, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_rst_fd", 8'hFF, 7'h7F, 1'b0);

    // Full decode sweep across two frames.
    do_reset(32'h01234567, 1'b1, 1'b0);
    for (int d = 0; d < 8; d++) begin
      logic [7:0] a;
      a = 8'h01 << d;
      run_to(33 + 4 * d);
      chk("sweep_lo", ~a, sw_lo[d], 1'b0);
      if (d == 1) data_reg = 32'h89ABCDEF;
    end
    for (int d = 0; d < 8; d++) begin
      logic [7:0] a;
      a = 8'h01 << d;
      run_to(65 + 4 * d);
      chk("sweep_hi", ~a, sw_hi[d], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
